mv_cmd_unpacker: RTL and testbench

- Upstream feeder for the 4x4 FP32 matrix-vector multiplier.
- Accepts one 32-bit command/data word per cycle over a valid/ready stream.
- Decodes LOAD_MATRIX and VERTEX packets. Drives the multiplier's matrix inputs (m_valid, m00..m33) and vertex inputs (in_valid, in_vertex_id, vx..vw).
- Guarantees a matrix update never overlaps a pending vertex and is applied atomically.

---
 rtl/mv_cmd_unpacker.sv | 195 +++++++++++++++++++
 tb/tb_mv_cmd_unpacker.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mv_cmd_unpacker.sv
// Command stream unpacker feeding the 4x4 FP32 matrix-vector multiplier.
// Latency: last payload word accepted at edge N -> m_valid / in_valid during the cycle after N.
// Backpressure: s_ready depends on state only; it drops for the commit cycle and while a vertex waits on in_ready.
module mv_cmd_unpacker #(
  parameter int IDW  = 8,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [31:0]     s_data,
  output logic            m_valid,
  output logic [31:0]     m00_o,
  output logic [31:0]     m01_o,
  output logic [31:0]     m02_o,
  output logic [31:0]     m03_o,
  output logic [31:0]     m10_o,
  output logic [31:0]     m11_o,
  output logic [31:0]     m12_o,
  output logic [31:0]     m13_o,
  output logic [31:0]     m20_o,
  output logic [31:0]     m21_o,
  output logic [31:0]     m22_o,
  output logic [31:0]     m23_o,
  output logic [31:0]     m30_o,
  output logic [31:0]     m31_o,
  output logic [31:0]     m32_o,
  output logic [31:0]     m33_o,
  output logic            in_valid,
  input  logic            in_ready,
  output logic [IDW-1:0]  in_vertex_id,
  output logic [31:0]     vx,
  output logic [31:0]     vy,
  output logic [31:0]     vz,
  output logic [31:0]     vw,
  output logic            err_bad_op,
  output logic [CNTW-1:0] vtx_count
);

  typedef enum logic [2:0] {
    ST_HDR,
    ST_MAT,
    ST_MCOMMIT,
    ST_VTX,
    ST_ISSUE
  } state_t;

  localparam logic [3:0] OP_LOAD_MATRIX = 4'h1;
  localparam logic [3:0] OP_VERTEX      = 4'h2;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     shadow_q [16];
  logic [31:0]     mat_q    [16];
  logic [31:0]     vtx_q    [4];
  logic [IDW-1:0]  id_q;
  logic            err_q;
  logic [CNTW-1:0] vcnt_q;
  logic            acc;
  logic [3:0]      opcode;

  assign opcode   = s_data[31:28];
  assign acc      = s_valid && s_ready;
  assign m_valid  = (state_q == ST_MCOMMIT);
  assign in_valid = (state_q == ST_ISSUE);

  // State and word-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HDR;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state decode; s_ready is driven from the current state alone.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_ready = 1'b0;
    case (state_q)
      ST_HDR: begin
        s_ready = 1'b1;
        if (s_valid) begin
          cnt_d = 4'd0;
          if (opcode == OP_LOAD_MATRIX) begin
            state_d = ST_MAT;
          end else if (opcode == OP_VERTEX) begin
            state_d = ST_VTX;
          end
        end
      end
      ST_MAT: begin
        s_ready = 1'b1;
        if (s_valid) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = ST_MCOMMIT;
          end
        end
      end
      ST_MCOMMIT: begin
        state_d = ST_HDR;
      end
      ST_VTX: begin
        s_ready = 1'b1;
        if (s_valid) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd3) begin
            state_d = ST_ISSUE;
            cnt_d   = 4'd0;
          end
        end
      end
      ST_ISSUE: begin
        if (in_ready) begin
          state_d = ST_HDR;
        end
      end
      default: begin
        state_d = ST_HDR;
      end
    endcase
  end

  // Payload capture, atomic matrix commit, error flag and vertex counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        shadow_q[i] <= '0;
        mat_q[i]    <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        vtx_q[i] <= '0;
      end
      id_q   <= '0;
      err_q  <= 1'b0;
      vcnt_q <= '0;
    end else begin
      if (acc && state_q == ST_HDR) begin
        if (opcode == OP_VERTEX) begin
          id_q <= s_data[IDW-1:0];
        end else if (opcode != OP_LOAD_MATRIX) begin
          err_q <= 1'b1;
        end
      end
      if (acc && state_q == ST_MAT) begin
        shadow_q[cnt_q] <= s_data;
        // The final word bypasses the shadow so the whole matrix becomes
        // visible together with m_valid in the commit cycle.
        if (cnt_q == 4'd15) begin
          for (int i = 0; i < 15; i++) begin
            mat_q[i] <= shadow_q[i];
          end
          mat_q[15] <= s_data;
        end
      end
      if (acc && state_q == ST_VTX) begin
        vtx_q[cnt_q[1:0]] <= s_data;
      end
      if (in_valid && in_ready) begin
        vcnt_q <= vcnt_q + CNTW'(1);
      end
    end
  end

  assign m00_o = mat_q[0];
  assign m01_o = mat_q[1];
  assign m02_o = mat_q[2];
  assign m03_o = mat_q[3];
  assign m10_o = mat_q[4];
  assign m11_o = mat_q[5];
  assign m12_o = mat_q[6];
  assign m13_o = mat_q[7];
  assign m20_o = mat_q[8];
  assign m21_o = mat_q[9];
  assign m22_o = mat_q[10];
  assign m23_o = mat_q[11];
  assign m30_o = mat_q[12];
  assign m31_o = mat_q[13];
  assign m32_o = mat_q[14];
  assign m33_o = mat_q[15];

  assign in_vertex_id = id_q;
  assign vx           = vtx_q[0];
  assign vy           = vtx_q[1];
  assign vz           = vtx_q[2];
  assign vw           = vtx_q[3];
  assign err_bad_op   = err_q;
  assign vtx_count    = vcnt_q;

endmodule

// File: tb/tb_mv_cmd_unpacker.sv
// Bench for mv_cmd_unpacker: directed packet sequence followed by a random packet stream.
// Expected results come from a packet-level event queue (matrices/vertices in stream order).
// in_ready is driven always-1, stalled for a set count, or random per cycle.
module tb_mv_cmd_unpacker;
  localparam int IDW  = 8;
  localparam int CNTW = 16;
  localparam int VW   = IDW + 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [31:0] s_data = '0;
  logic m_valid;
  logic [31:0] m00_o, m01_o, m02_o, m03_o, m10_o, m11_o, m12_o, m13_o;
  logic [31:0] m20_o, m21_o, m22_o, m23_o, m30_o, m31_o, m32_o, m33_o;
  logic in_valid;
  logic in_ready = 1'b1;
  logic [IDW-1:0] in_vertex_id;
  logic [31:0] vx, vy, vz, vw;
  logic err_bad_op;
  logic [CNTW-1:0] vtx_count;

  always #5 clk = ~clk;

  mv_cmd_unpacker #(.IDW(IDW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid),
    .m00_o(m00_o), .m01_o(m01_o), .m02_o(m02_o), .m03_o(m03_o),
    .m10_o(m10_o), .m11_o(m11_o), .m12_o(m12_o), .m13_o(m13_o),
    .m20_o(m20_o), .m21_o(m21_o), .m22_o(m22_o), .m23_o(m23_o),
    .m30_o(m30_o), .m31_o(m31_o), .m32_o(m32_o), .m33_o(m33_o),
    .in_valid(in_valid), .in_ready(in_ready), .in_vertex_id(in_vertex_id),
    .vx(vx), .vy(vy), .vz(vz), .vw(vw),
    .err_bad_op(err_bad_op), .vtx_count(vtx_count)
  );

  logic [511:0] dut_mat;
  logic [VW-1:0] vout;
  assign dut_mat = {m33_o, m32_o, m31_o, m30_o, m23_o, m22_o, m21_o, m20_o,
                    m13_o, m12_o, m11_o, m10_o, m03_o, m02_o, m01_o, m00_o};
  assign vout = {in_vertex_id, vx, vy, vz, vw};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: completed packets in stream order.
  bit            evq_is_mat[$];
  logic [511:0]  matq[$];
  logic [VW-1:0] vtxq[$];
  logic [511:0]  committed = '0;
  logic [CNTW-1:0] exp_vcnt = '0;
  bit  exp_err = 1'b0;
  int  mat_done_cyc = 0, vtx_done_cyc = 0, last_hs_cyc = 0, hdr_cyc = 0;

  // Driver context for the word currently offered.
  bit cur_bad = 0, cur_last = 0, cur_is_mat = 0, accepted = 0;
  logic [511:0]  cur_mat = '0;
  logic [VW-1:0] cur_vtx = '0;
  int stall_left = 0, rdy_mode = 0, gap_mode = 0;
  bit prev_iv = 0;
  logic [VW-1:0] prev_vout = '0;
  int iv_run = 0, last_run = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample pre-edge handshakes, advance, update model and compare.
  task automatic tick();
    bit acc, hs, was_rst, front_ok;
    logic [VW-1:0] hs_v;
    logic [511:0] em;
    acc = s_valid && s_ready;
    hs = in_valid && in_ready;
    hs_v = vout;
    was_rst = rst;
    @(posedge clk);
    #1;
    cyc++;
    accepted = acc && !was_rst;
    if (was_rst) begin
      evq_is_mat.delete(); matq.delete(); vtxq.delete();
      committed = '0; exp_vcnt = '0; exp_err = 1'b0; iv_run = 0;
    end else begin
      if (acc && cur_bad) exp_err = 1'b1;
      if (acc && cur_last) begin
        evq_is_mat.push_back(cur_is_mat);
        if (cur_is_mat) begin matq.push_back(cur_mat); mat_done_cyc = cyc; end
        else begin vtxq.push_back(cur_vtx); vtx_done_cyc = cyc; end
      end
      if (hs) begin
        front_ok = (evq_is_mat.size() > 0) && !evq_is_mat[0];
        check("hs_order", front_ok, 1'b1);
        if (front_ok) begin
          evq_is_mat.delete(0);
          check("hs_vertex", hs_v, vtxq.pop_front());
        end
        exp_vcnt++;
        last_run = iv_run; iv_run = 0; last_hs_cyc = cyc;
        check("iv_drop", in_valid, 1'b0);
      end else if (prev_iv) begin
        check("iv_hold", {in_valid, vout}, {1'b1, prev_vout});
      end
      if (m_valid) begin
        front_ok = (evq_is_mat.size() > 0) && evq_is_mat[0];
        check("mv_order", front_ok, 1'b1);
        if (front_ok) begin
          evq_is_mat.delete(0);
          em = matq.pop_front();
          check("mv_data", dut_mat, em);
          committed = em;
          check("mv_latency", cyc, mat_done_cyc);
        end
      end else begin
        check("m_hold", dut_mat, committed);
      end
      if (in_valid && !prev_iv) check("iv_latency", cyc, vtx_done_cyc);
      if (in_valid) iv_run++;
    end
    check("vtx_count", vtx_count, exp_vcnt);
    check("err_bad_op", err_bad_op, exp_err);
    check("s_ready", s_ready, !(m_valid || in_valid));
    prev_iv = in_valid;
    prev_vout = vout;
    if (in_valid && stall_left > 0) begin
      in_ready = 1'b0;
      stall_left--;
    end else begin
      in_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit bad, input bit last);
    int n;
    if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
      s_valid = 1'b0;
      tick();
    end
    s_valid = 1'b1; s_data = w; cur_bad = bad; cur_last = last;
    n = 0; accepted = 0;
    while (!accepted && n < 100) begin tick(); n++; end
    checks++;
    assert (accepted) else begin
      errors++;
      $error("FAIL accept_timeout observed=0 expected=1");
    end
    s_valid = 1'b0; cur_bad = 0; cur_last = 0;
  endtask

  task automatic send_mat(input logic [31:0] hdr, input logic [511:0] m);
    cur_is_mat = 1; cur_mat = m;
    send_word(hdr, 0, 0);
    hdr_cyc = cyc;
    for (int i = 0; i < 16; i++) send_word(m[i*32 +: 32], 0, i == 15);
  endtask

  task automatic send_vtx(input logic [31:0] hdr, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] z, input logic [31:0] w);
    cur_is_mat = 0; cur_vtx = {hdr[IDW-1:0], x, y, z, w};
    send_word(hdr, 0, 0);
    send_word(x, 0, 0); send_word(y, 0, 0); send_word(z, 0, 0); send_word(w, 0, 1);
  endtask

  task automatic drain();
    int n;
    s_valid = 1'b0; n = 0;
    while ((evq_is_mat.size() > 0 || in_valid || m_valid) && n < 300) begin tick(); n++; end
    check("drain_empty", evq_is_mat.size(), 0);
  endtask

  function automatic logic [511:0] rand_mat();
    logic [511:0] m;
    for (int i = 0; i < 16; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  task automatic reset_pulse();
    rst = 1'b1; s_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_outputs", {m_valid, in_valid, err_bad_op, vtx_count, vout, dut_mat}, '0);
    check("rst_s_ready", s_ready, 1'b1);
  endtask

  initial begin
    logic [511:0] ident, m;
    int op;
    ident = '0;
    for (int i = 0; i < 4; i++) ident[(i*5)*32 +: 32] = 32'h3F80_0000;

    // Power-on reset.
    rst = 1'b1; tick();
    reset_pulse();

    // Identity matrix load.
    send_mat(32'h1000_0000, ident);
    drain();
    check("ident_held", dut_mat, ident);

    // Single vertex with in_ready high.
    send_vtx(32'h2000_0005, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000);
    drain();
    check("v1_run", last_run, 1);
    check("v1_count", vtx_count, 1);

    // Same vertex held off for 7 cycles.
    stall_left = 7;
    send_vtx(32'h2000_0005, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000);
    drain();
    check("bp_run", last_run, 8);
    check("bp_count", vtx_count, 2);

    // Vertex then matrix back to back while the vertex is stalled.
    stall_left = 5;
    last_hs_cyc = 1 << 30;
    send_vtx(32'h2ABC_D009, $urandom, $urandom, $urandom, $urandom);
    send_mat(32'h1000_0000, rand_mat());
    check("ord_hdr_after_hs", hdr_cyc > last_hs_cyc, 1'b1);
    drain();

    // Unknown opcode, then a vertex with s_valid toggling.
    send_word(32'hF000_0000, 1, 0);
    gap_mode = 1;
    send_vtx(32'h2000_0077, 32'h7FC0_0001, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF);
    gap_mode = 0;
    drain();
    check("err_sticky", err_bad_op, 1'b1);

    // Reset after 7 of 16 matrix payload words.
    m = rand_mat();
    send_word(32'h1000_0000, 0, 0);
    for (int i = 0; i < 7; i++) send_word(m[i*32 +: 32], 0, 0);
    reset_pulse();
    for (int i = 0; i < 3; i++) tick();
    m = rand_mat();
    send_mat(32'h1000_0000, m);
    drain();
    check("post_rst_mat", dut_mat, m);

    // Random packet stream with random gaps and random in_ready.
    rdy_mode = 1; gap_mode = 2;
    for (int p = 0; p < 60; p++) begin
      op = $urandom_range(0, 9);
      if (op < 4) begin
        send_mat({4'h1, 28'($urandom)}, rand_mat());
      end else if (op < 9) begin
        send_vtx({4'h2, 28'($urandom)}, $urandom, $urandom, $urandom, $urandom);
      end else begin
        send_word({4'($urandom_range(3, 15)), 28'($urandom)}, 1, 0);
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
